aes_mode_chain_ctrl: RTL
========================

Name: aes_mode_chain_ctrl

Overview:
Multi-channel block-cipher mode sequencer. It sits between the host request port and one shared AES-128 block-cipher core. It applies ECB/CBC/CFB/OFB/CTR chaining around that core and keeps an independent chain register per channel, so up to NUM_CH message streams can interleave block by block. It replaces the single-stream chaining inside aes128 and adds per-channel state, CTR counter-width control and a valid/ready handshake with backpressure.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
BLOCK_W, 128, block width in bits (matches the core)
CTR_W, 32, number of low bits incremented in CTR mode (1..BLOCK_W)
CH_W, $clog2(NUM_CH) (min 1), derived channel-index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid and req_ready are both high
req_ch  in  CH_W  channel index
req_decipher  in  1  0 cipher, 1 decipher
req_chain  in  1  1 continue from chain register, 0 start from req_iv
req_mode  in  3  0 ECB, 1 CBC, 2 CFB (full block), 3 OFB, 4 CTR
req_data  in  BLOCK_W  input block
req_iv  in  BLOCK_W  initial vector / initial counter
core_start  out  1  one-cycle start pulse to the core
core_decipher  out  1  core direction
core_in  out  BLOCK_W  core input block
core_done  in  1  core result valid (one-cycle pulse)
core_out  in  BLOCK_W  core result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_ch  out  CH_W  channel of the response
rsp_data  out  BLOCK_W  output block
rsp_err  out  1  illegal mode or channel

Behaviour:
- Reset (clk edge with rst=1): FSM goes to IDLE. All chain_q[0..NUM_CH-1] cleared to 0. Outputs reset to: req_ready=0 for the reset cycle, then 1 in IDLE; core_start=0; core_decipher=0; core_in=0; rsp_valid=0; rsp_ch=0; rsp_data=0; rsp_err=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: req_ready=1. On accept, capture the request and go to ISSUE. If req_mode>4 or req_ch>=NUM_CH, go directly to RESP with rsp_err=1 and rsp_data=0; no core call and no chain update.
  - ISSUE: core_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: on core_done, register rsp_data, update chain_q[ch], and go to RESP. core_done in any other state is ignored.
  - RESP: rsp_valid=1. rsp_ch, rsp_data and rsp_err are held stable until rsp_ready=1, then go to IDLE.
- req_ready is 0 in ISSUE, WAIT and RESP. There is no pipelining: at most one block is in flight.
- core_in and core_decipher are valid from ISSUE through WAIT and are held stable.
- Latency: accept at cycle T; core_start at T+1; core_done at D>=T+2; rsp_valid at D+1. Back-to-back: the next request is accepted the cycle after the rsp handshake.
- Start value S = req_chain ? chain_q[ch] : req_iv.
- Mode rules ("^" = bitwise XOR):
  - ECB: core_in=data; core_decipher=req_decipher; out=core_out; chain unchanged.
  - CBC cipher: core_in=data^S; core_decipher=0; out=core_out; chain<=core_out.
  - CBC decipher: core_in=data; core_decipher=1; out=core_out^S; chain<=data.
  - CFB: core_in=S; core_decipher=0; out=core_out^data; chain<=(cipher ? out : data).
  - OFB: core_in=S; core_decipher=0; out=core_out^data; chain<=core_out. Cipher and decipher are identical.
  - CTR: core_in=S; core_decipher=0; out=core_out^data; chain<={S[BLOCK_W-1:CTR_W], S[CTR_W-1:0]+1}.
- CTR wrap-around: low CTR_W bits all ones wrap to 0. There is no carry into the upper bits.
- Only chain_q[req_ch] is written. Other channels are untouched.
- Reset during ISSUE, WAIT or RESP aborts the operation: the response is dropped and a late core_done is ignored.
- rst has priority over every other event in the same cycle.

Test Plan:
- OFB ch0, req_chain=0, IV 000102030405060708090a0b0c0d0e0f, data 6bc1bee22e409f96e93d7e117393172a, AES reference core model -> rsp_data 3b3fd92eb72dad20333449f8e83cfb4a, rsp_err=0.
- Interleave: after the OFB block above, ch1 OFB with IV 0 and arbitrary data; then ch0 req_chain=1, data ae2d8a571e03ac9c9eb76fac45af8e51 -> 7789508d16918f03f53c52dac54ed825. This proves per-channel isolation.
- CBC ch2 cipher, IV 000102..0f, data 6bc1bee2...172a -> 7649abac8119b246cee98e9b12e9197d. Then CBC decipher of that ciphertext with req_chain=0 and the same IV -> original plaintext.
- CTR ch3, IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data 6bc1...172a -> 874d6191b620e3261bef6864990db6ce; chain_q[3] = f0f1f2f3f4f5f6f7f8f9fafbfcfdff00. Second CTR case, IV ...ffffffff -> chain low 32 bits = 00000000, upper 96 bits unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0, no extra core_start pulse.
- Errors and reset: req_mode=5 -> rsp_err=1, rsp_data=0, no core_start. Assert rst in WAIT, then pulse core_done -> no rsp_valid, and all chain registers read 0 via a subsequent req_chain=1 ECB-free OFB check.

Source files
------------

// File: rtl/aes_mode_chain_ctrl.sv
// Multi-channel block-cipher mode sequencer.
// Wraps one shared block-cipher core with ECB/CBC/CFB/OFB/CTR chaining and keeps
// an independent chain register per channel so message streams can interleave
// block by block. One block in flight at a time; valid/ready on both host sides.
module aes_mode_chain_ctrl #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned BLOCK_W = 128,
   parameter int unsigned CTR_W   = 32,
   parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [CH_W-1:0]    req_ch,
   input  logic               req_decipher,
   input  logic               req_chain,
   input  logic [2:0]         req_mode,
   input  logic [BLOCK_W-1:0] req_data,
   input  logic [BLOCK_W-1:0] req_iv,
   output logic               core_start,
   output logic               core_decipher,
   output logic [BLOCK_W-1:0] core_in,
   input  logic               core_done,
   input  logic [BLOCK_W-1:0] core_out,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [CH_W-1:0]    rsp_ch,
   output logic [BLOCK_W-1:0] rsp_data,
   output logic               rsp_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [2:0] MODE_ECB = 3'd0;
   localparam logic [2:0] MODE_CBC = 3'd1;
   localparam logic [2:0] MODE_CFB = 3'd2;
   localparam logic [2:0] MODE_OFB = 3'd3;
   localparam logic [2:0] MODE_CTR = 3'd4;

   // Low CTR_W bits of the counter; upper bits never receive a carry.
   localparam logic [BLOCK_W-1:0] CTR_MASK = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_W);
   localparam logic [CH_W:0]      NUM_CH_V = NUM_CH[CH_W:0];

   state_t             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [2:0]         mode_q, mode_d;
   logic               dec_q, dec_d;
   logic [BLOCK_W-1:0] data_q, data_d;
   logic [BLOCK_W-1:0] s_q, s_d;
   logic [BLOCK_W-1:0] core_in_q, core_in_d;
   logic               core_dec_q, core_dec_d;
   logic [BLOCK_W-1:0] rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic [BLOCK_W-1:0] chain_q [NUM_CH];
   logic [BLOCK_W-1:0] chain_d [NUM_CH];

   logic               req_ch_ok;
   logic [BLOCK_W-1:0] req_chain_val;
   logic [BLOCK_W-1:0] start_val;
   logic [BLOCK_W-1:0] ks_xor_data;
   logic [BLOCK_W-1:0] ctr_next;

   // Request decode: channel range check, start value and next counter value.
   always_comb begin
      req_ch_ok     = ({1'b0, req_ch} < NUM_CH_V);
      req_chain_val = req_ch_ok ? chain_q[req_ch] : '0;
      start_val     = req_chain ? req_chain_val : req_iv;
      ks_xor_data   = core_out ^ data_q;
      ctr_next      = (s_q & ~CTR_MASK) | ((s_q + 1'b1) & CTR_MASK);
   end

   // Next-state, captured request, core drive and chain update.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      mode_d     = mode_q;
      dec_d      = dec_q;
      data_d     = data_q;
      s_d        = s_q;
      core_in_d  = core_in_q;
      core_dec_d = core_dec_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      chain_d    = chain_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               ch_d      = req_ch;
               mode_d    = req_mode;
               dec_d     = req_decipher;
               data_d    = req_data;
               s_d       = start_val;
               rsp_err_d = 1'b0;
               if ((req_mode > MODE_CTR) || !req_ch_ok) begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
                  state_d    = ST_RESP;
               end else begin
                  unique case (req_mode)
                     MODE_ECB: begin
                        core_in_d  = req_data;
                        core_dec_d = req_decipher;
                     end
                     MODE_CBC: begin
                        core_in_d  = req_decipher ? req_data : (req_data ^ start_val);
                        core_dec_d = req_decipher;
                     end
                     default: begin
                        // CFB, OFB and CTR only ever run the core forward on S.
                        core_in_d  = start_val;
                        core_dec_d = 1'b0;
                     end
                  endcase
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_done) begin
               state_d = ST_RESP;
               unique case (mode_q)
                  MODE_ECB: begin
                     rsp_data_d = core_out;
                  end
                  MODE_CBC: begin
                     if (dec_q) begin
                        rsp_data_d    = core_out ^ s_q;
                        chain_d[ch_q] = data_q;
                     end else begin
                        rsp_data_d    = core_out;
                        chain_d[ch_q] = core_out;
                     end
                  end
                  MODE_CFB: begin
                     rsp_data_d    = ks_xor_data;
                     chain_d[ch_q] = dec_q ? data_q : ks_xor_data;
                  end
                  MODE_OFB: begin
                     rsp_data_d    = ks_xor_data;
                     chain_d[ch_q] = core_out;
                  end
                  default: begin
                     rsp_data_d    = ks_xor_data;
                     chain_d[ch_q] = ctr_next;
                  end
               endcase
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over every other event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ch_q       <= '0;
         mode_q     <= '0;
         dec_q      <= 1'b0;
         data_q     <= '0;
         s_q        <= '0;
         core_in_q  <= '0;
         core_dec_q <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            chain_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         mode_q     <= mode_d;
         dec_q      <= dec_d;
         data_q     <= data_d;
         s_q        <= s_d;
         core_in_q  <= core_in_d;
         core_dec_q <= core_dec_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         chain_q    <= chain_d;
      end
   end

   assign req_ready     = (state_q == ST_IDLE) && !rst;
   assign core_start    = (state_q == ST_ISSUE);
   assign core_decipher = core_dec_q;
   assign core_in       = core_in_q;
   assign rsp_valid     = (state_q == ST_RESP);
   assign rsp_ch        = ch_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;

endmodule
